req_arbiter: RTL

// - Shares one downstream resource (bus/port) among N requesters.
// - A priority encoder picks one requester. The grant is held while that owner keeps req high.
// - Each grant is reported as one-hot plus a binary index, in the style of the codebase's 8:3 encoder.
// - Sits between requester blocks and the shared resource's select mux.

---
 rtl/req_arbiter_pkg.sv | 10 +
 rtl/req_arbiter_if.sv | 11 +
 rtl/req_arbiter_prio_enc.sv | 16 +
 rtl/req_arbiter.sv | 93 +++++++++
 4 files changed

// File: rtl/req_arbiter_pkg.sv
// arb_pkg: shared state type, size limit and one-hot helper for req_arbiter.
package arb_pkg;
    typedef enum logic [0:0] {ARB_IDLE, ARB_BUSY} arb_state_t;
    localparam int ARB_N_MAX = 16;
    function automatic logic [ARB_N_MAX-1:0] onehot(input int idx, input int n);
        logic [ARB_N_MAX-1:0] one;
        one = {{(ARB_N_MAX-1){1'b0}}, 1'b1};
        return (idx >= 0 && idx < n) ? one << idx : '0;
    endfunction
endpackage

// File: rtl/req_arbiter_if.sv
// req_arbiter_if: request/grant bundle between requesters (master) and the arbiter (slave).
interface req_arbiter_if #(parameter int N = 8);
    localparam int IDX_W = $clog2(N);
    logic [N-1:0]     req;
    logic [N-1:0]     gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_valid;
    logic             timeout;
    modport master (output req, input gnt, gnt_idx, gnt_valid, timeout);
    modport slave (input req, output gnt, gnt_idx, gnt_valid, timeout);
endinterface

// File: rtl/req_arbiter_prio_enc.sv
// prio_enc_n: combinational N-input priority encoder, lowest set bit wins, idx=0 when empty.
module prio_enc_n #(
    parameter int N = 8
) (
    input  logic [N-1:0]         in,
    output logic [$clog2(N)-1:0] idx,
    output logic                 valid
);
    localparam int IDX_W = $clog2(N);
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--)
            if (in[i]) idx = IDX_W'(i);
        valid = |in;
    end
endmodule

// File: rtl/req_arbiter.sv
// req_arbiter: N-way grant-and-hold arbiter with MAX_HOLD revoke; ARB_ROUND_ROBIN_EN selects round-robin over fixed priority.
module req_arbiter
    import arb_pkg::*;
#(
    parameter int N        = 8,
    parameter int MAX_HOLD = 16
) (
    input logic         clk,
    input logic         rst,
    req_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(N);
    localparam int HW    = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    arb_state_t       state_q, state_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic             timeout_q, timeout_d;
    logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
    logic [N-1:0]     enc_in;
    logic [IDX_W-1:0] enc_idx, winner;
    logic             enc_valid, owner_req, expire;
`ifdef ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    // Rotate so the search starts at rr_ptr, then map the encoded index back mod N.
    always_comb begin
        for (int i = 0; i < N; i++)
            enc_in[i] = bus.req[(i + int'(rr_ptr_q)) % N];
        winner   = IDX_W'((int'(enc_idx) + int'(rr_ptr_q)) % N);
        rr_ptr_d = (state_q == ARB_IDLE && enc_valid) ? IDX_W'((int'(winner) + 1) % N) : rr_ptr_q;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) rr_ptr_q <= '0;
        else     rr_ptr_q <= rr_ptr_d;
`else
    assign enc_in = bus.req;
    assign winner = enc_idx;
`endif
    prio_enc_n #(.N(N)) u_enc (
        .in   (enc_in),
        .idx  (enc_idx),
        .valid(enc_valid)
    );
    assign owner_req = bus.req[gnt_idx_q];
    assign expire    = (MAX_HOLD != 0) && (hold_cnt_q == HW'(MAX_HOLD - 1));
    // An owner dropping req on the expiry edge is a plain release, so timeout follows owner_req.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;
        hold_cnt_d  = hold_cnt_q;
        if (state_q == ARB_IDLE) begin
            if (enc_valid) begin
                state_d     = ARB_BUSY;
                gnt_d       = N'(onehot(int'(winner), N));
                gnt_idx_d   = winner;
                gnt_valid_d = 1'b1;
                hold_cnt_d  = '0;
            end
        end else if (!owner_req || expire) begin
            state_d     = ARB_IDLE;
            gnt_d       = '0;
            gnt_idx_d   = '0;
            gnt_valid_d = 1'b0;
            timeout_d   = owner_req;
            hold_cnt_d  = '0;
        end else begin
            hold_cnt_d = (hold_cnt_q == '1) ? hold_cnt_q : hold_cnt_q + 1'b1;
        end
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q     <= ARB_IDLE;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            hold_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    assign bus.gnt       = gnt_q;
    assign bus.gnt_idx   = gnt_idx_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.timeout   = timeout_q;
endmodule
